// File: rtl/jk_bank_arbiter_pkg.sv
// Shared types for the JK bank arbiter: opcodes, FSM states,
// and the opcode to J/K level decode.
package jk_bank_arbiter_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CLK_HI,
    S_CLK_LO,
    S_CLRP,
    S_SETTLE,
    S_CHECK
  } state_e;

  // Returns {j, k} for one selected bit.
  function automatic logic [1:0] jk_decode(input logic [1:0] op);
    logic [1:0] jk;
    case (op)
      OP_RST:  jk = 2'b01;
      OP_SET:  jk = 2'b10;
      OP_TGL:  jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted req at or after ptr wins.
// Ports: req, ptr in; one-hot gnt and valid out (combinational).
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);

  logic [PW:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ))
        idx = idx - (PW+1)'(NREQ);
      if (!valid && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin command arbiter and clock sequencer for a JK flip-flop bank.
// Ports: clk/clr, per-requester req/op/mask, bank_clr_req; gnt/done/busy;
// bank drive ff_j/ff_k/ff_clk/ff_clr_n, ff_q return; shadow_q, mismatch.
module jk_bank_arbiter
  import jk_bank_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 4,
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NREQ-1:0]    req,
  input  logic [2*NREQ-1:0]  op,
  input  logic [WIDTH*NREQ-1:0] mask,
  input  logic               bank_clr_req,
  output logic [NREQ-1:0]    gnt,
  output logic               done,
  output logic               busy,
  output logic [WIDTH-1:0]   ff_j,
  output logic [WIDTH-1:0]   ff_k,
  output logic               ff_clk,
  output logic               ff_clr_n,
  input  logic [WIDTH-1:0]   ff_q,
  output logic [WIDTH-1:0]   shadow_q,
  output logic               mismatch
);

  localparam int PW = $clog2(NREQ);

  state_e           state;
  logic [7:0]       cnt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gidx_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] mask_q;

  logic [NREQ-1:0]  arb_gnt;
  logic             arb_valid;
  logic [PW-1:0]    sel_idx;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  logic [1:0]       sel_jk;
  logic [WIDTH-1:0] shadow_next;
  logic [PW-1:0]    ptr_next;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    sel_idx  = '0;
    sel_op   = '0;
    sel_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_idx  = PW'(i);
        sel_op   = op[2*i +: 2];
        sel_mask = mask[WIDTH*i +: WIDTH];
      end
    end
  end

  assign sel_jk = jk_decode(sel_op);

  assign ptr_next = (gidx_q == PW'(NREQ-1)) ?
                    '0 : gidx_q + PW'(1);

  always_comb begin
    shadow_next = shadow_q;
    case (op_q)
      OP_SET:  shadow_next = shadow_q | mask_q;
      OP_RST:  shadow_next = shadow_q & ~mask_q;
      OP_TGL:  shadow_next = shadow_q ^ mask_q;
      default: shadow_next = shadow_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ptr      <= '0;
      gidx_q   <= '0;
      op_q     <= OP_HOLD;
      mask_q   <= '0;
      gnt      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ff_j     <= '0;
      ff_k     <= '0;
      ff_clk   <= 1'b0;
      ff_clr_n <= 1'b0;
      shadow_q <= '0;
      mismatch <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          ff_clr_n <= 1'b1;
          cnt      <= '0;
          if (bank_clr_req) begin
            state    <= S_CLRP;
            ff_clr_n <= 1'b0;
            shadow_q <= '0;
            busy     <= 1'b1;
          end else if (arb_valid) begin
            state  <= S_SETUP;
            gnt    <= arb_gnt;
            gidx_q <= sel_idx;
            op_q   <= sel_op;
            mask_q <= sel_mask;
            ff_j   <= {WIDTH{sel_jk[1]}} & sel_mask;
            ff_k   <= {WIDTH{sel_jk[0]}} & sel_mask;
            busy   <= 1'b1;
          end
        end
        S_SETUP: begin
          if (cnt == 8'(SETUP_CYC-1)) begin
            state  <= S_CLK_HI;
            ff_clk <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_CLK_HI: begin
          if (cnt == 8'(PULSE_CYC-1)) begin
            state    <= S_CLK_LO;
            ff_clk   <= 1'b0;
            ff_j     <= '0;
            ff_k     <= '0;
            shadow_q <= shadow_next;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_CLK_LO: begin
          if (cnt == 8'(PULSE_CYC-1)) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_CLRP: begin
          if (cnt == 8'(PULSE_CYC-1)) begin
            state    <= S_SETTLE;
            ff_clr_n <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_SETTLE: begin
          if (cnt == 8'(SETTLE_CYC-1)) begin
            // Compare on entry so mismatch rises together with done.
            state <= S_CHECK;
            done  <= 1'b1;
            cnt   <= '0;
            if (ff_q != shadow_q)
              mismatch <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_CHECK: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          gnt   <= '0;
          // gnt is zero after a bank clear, which leaves ptr alone.
          if (gnt != '0)
            ptr <= ptr_next;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
